// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_pkg
//  Description : Shared next-PC select encodings and helpers for the PC /
//                instruction-fetch block.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

    // Next-PC select encodings driven by the PC-source logic
    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // Sequential instruction stride in bytes
    localparam logic [31:0] C_PC_STEP = 32'd4;

    // Sign-extended, word-scaled 16-bit branch displacement
    function automatic logic [31:0] branch_offset(input logic [31:0] instr);
        return {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_npc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_npc_calc
//  Description : Combinational next-PC selection: sequential, PC-relative
//                branch, pseudo-direct jump and register-indirect jump.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit_npc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    // Opcode bits and the register low bits never influence the target
    logic w_unused;
    assign w_unused = ^{instr[31:26], rs_data[1:0]};

    // Link value; wraps naturally at the top of the address space
    assign pc_plus4 = pc + C_PC_STEP;

    // Select the next PC; every sum wraps mod 2^32
    always_comb begin
        next_pc = pc_plus4;
        case (npc_op)
            NPC_PLUS4:  next_pc = pc_plus4;
            NPC_BRANCH: next_pc = pc_plus4 + branch_offset(instr);
            NPC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_JR:     next_pc = {rs_data[31:2], 2'b00};
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Owns the architectural PC, fetches one instruction over a
//                req/ready handshake, holds it for the datapath and advances
//                the PC on retire.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic        retire,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_next_pc;
    logic        w_fetch_done;
    logic        w_retire_go;

    // A response only counts while actually fetching; stall beats retire
    assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
    assign w_retire_go  = (r_state == S_EXEC) && retire && !stall;

    pc_fetch_unit_npc_calc u_npc_calc (
        .pc       (r_pc),
        .instr    (r_instr),
        .npc_op   (npc_op),
        .rs_data  (rs_data),
        .next_pc  (w_next_pc),
        .pc_plus4 (pc_plus4)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: S_RST always lasts exactly one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:   w_state_next = S_FETCH;
            S_FETCH: if (w_fetch_done) w_state_next = S_EXEC;
            S_EXEC:  if (w_retire_go)  w_state_next = S_FETCH;
            default: w_state_next = S_RST;
        endcase
    end

    // PC and held-instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
        end else begin
            if (w_fetch_done) begin
                r_instr <= imem_rdata;
            end
            if (w_retire_go) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Outputs decoded from state
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            S_FETCH: imem_req    = 1'b1;
            S_EXEC:  instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed self-checking bench for pc_fetch_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  npc_op;
    logic [31:0] rs_data;
    logic        retire;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_PLUS4  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;
    localparam logic [1:0] OP_JR     = 2'b11;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc_op      (npc_op),
        .rs_data     (rs_data),
        .retire      (retire),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From S_FETCH: deliver one word immediately, then retire it with op/rs
    task automatic run_instr(input logic [31:0] word, input logic [1:0] op,
                             input logic [31:0] rs);
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        retire     = 1'b1;
        stall      = 1'b0;
        npc_op     = op;
        rs_data    = rs;
        tick();
        retire     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hAAAA_5555;
        retire = 1'b0; stall = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL rst_pc: got %h want 00003000", pc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
        checks++; if (pc_plus4 !== 32'h3004) begin errors++; $display("FAIL rst_pc_plus4: got %h want 00003004", pc_plus4); end
        rst = 1'b0;
        tick();
        // S_RST ignores the tied-high ready, so the stale word is not captured
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL fetch_addr: got %h want 00003000", imem_addr); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL srst_ready_ignored: got %h want 0", instr); end
    endtask

    task automatic test_plus4();
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL p4_instr: got %h want 20080005", instr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL p4_valid: got %b want 1", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL p4_req_exec: got %b want 0", imem_req); end
        imem_ready = 1'b0; retire = 1'b1; npc_op = OP_PLUS4;
        tick();
        retire = 1'b0;
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL p4_pc: got %h want 00003004", pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL p4_valid_one_cycle: got %b want 0", instr_valid); end
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL p4_addr: got %h want 00003004", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL p4_req_refetch: got %b want 1", imem_req); end
    endtask

    task automatic test_branch();
        run_instr(32'h0, OP_JR, 32'h3010);
        checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL br_setup: got %h want 00003010", pc); end
        run_instr(32'h1000_FFFC, OP_BRANCH, 32'h0);
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL br_back: got %h want 00003004", pc); end
        run_instr(32'h0, OP_JR, 32'h3010);
        run_instr(32'h1000_0003, OP_BRANCH, 32'h0);
        checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL br_fwd: got %h want 00003020", pc); end
    endtask

    task automatic test_jump();
        run_instr(32'h0, OP_JR, 32'h3000);
        run_instr(32'h0800_0C10, OP_JUMP, 32'h0);
        checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL jump: got %h want 00003040", pc); end
        run_instr(32'h0, OP_JR, 32'h3047);
        checks++; if (pc !== 32'h3044) begin errors++; $display("FAIL jr_align: got %h want 00003044", pc); end
        checks++; if (pc_plus4 !== 32'h3048) begin errors++; $display("FAIL jr_pc_plus4: got %h want 00003048", pc_plus4); end
    endtask

    task automatic test_wait_stall();
        imem_ready = 1'b0; imem_rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
            checks++; if (imem_addr !== 32'h3044) begin errors++; $display("FAIL wait_addr[%0d]: got %h want 00003044", i, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
        end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_instr: got %h want deadbeef", instr); end
        // Ready stays high with a different word: ignored while executing
        imem_rdata = 32'h5555_AAAA; retire = 1'b1; stall = 1'b1; npc_op = OP_PLUS4;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h3044) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 00003044", i, pc); end
            checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_instr[%0d]: got %h want deadbeef", i, instr); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
        end
        imem_ready = 1'b0; stall = 1'b0;
        tick();
        retire = 1'b0;
        checks++; if (pc !== 32'h3048) begin errors++; $display("FAIL unstall_pc: got %h want 00003048", pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL unstall_valid: got %b want 0", instr_valid); end
    endtask

    task automatic test_reset_mid_fetch();
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", imem_req); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_rst_instr: got %h want 0", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL mid_rst_pc: got %h want 00003000", pc); end
        rst = 1'b0;
        tick();
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_post_instr: got %h want 0", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid: got %b want 0", instr_valid); end
        checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL mid_refetch_addr: got %h want 00003000", imem_addr); end
        imem_rdata = 32'h2009_0007;
        tick();
        checks++; if (instr !== 32'h2009_0007) begin errors++; $display("FAIL mid_refetch_instr: got %h want 20090007", instr); end
        imem_ready = 1'b0;
    endtask

    task automatic test_wrap();
        // Currently executing; retire to the last word of the address space
        retire = 1'b1; npc_op = OP_JR; rs_data = 32'hFFFF_FFFF;
        tick();
        retire = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_pc: got %h want fffffffc", pc); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); end
        // Jump region comes from the wrapped pc+4, not from pc
        run_instr(32'h0BFF_FFFF, OP_JUMP, 32'h0);
        checks++; if (pc !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_jump: got %h want 0ffffffc", pc); end
        run_instr(32'h0, OP_JR, 32'hFFFF_FFFC);
        run_instr(32'h0, OP_PLUS4, 32'h0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 0", pc); end
    endtask

    initial begin
        rst = 1'b1; npc_op = OP_PLUS4; rs_data = 32'h0; retire = 1'b0;
        stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_plus4();
        test_branch();
        test_jump();
        test_wait_stall();
        test_reset_mid_fetch();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
